hist_ram_avmm_slave: RTL and testbench
======================================

# hist_ram_avmm_slave

Avalon-MM slave histogram memory that sits directly downstream of the exported `master_0_master` port of the SRAM_SC system and serves its reads and writes. It holds 2^BIN_AW 32-bit saturating bin counters in on-chip RAM. A single write to the INCR register performs a pipelined read-modify-write increment, one per cycle. It also provides direct bin read/write, a bulk clear sweep, a total-event counter and sticky status flags.

## Interface
- BIN_AW, 8, bin index width; NUM_BINS = 2^BIN_AW (BIN_AW ≤ 10)
- clk_clk  in  1  single clock for all logic
- reset_reset_n  in  1  asynchronous, active-low reset
- s0_address  in  32  byte address from `master_0_master_address`; bits [1:0] ignored
- s0_read  in  1  read request
- s0_write  in  1  write request
- s0_writedata  in  32  write data
- s0_byteenable  in  4  byte enables
- s0_readdata  out  32  read data, valid when s0_readdatavalid=1
- s0_waitrequest  out  1  stall; a command is accepted when (read|write) && !waitrequest
- s0_readdatavalid  out  1  one-cycle pulse per accepted read

## Operation
- Address map, selected by byte address bit 12:
  - 0: bin array; word (addr[BIN_AW+1:2]) = bin; addr bits [11:BIN_AW+2] are ignored (aliasing).
  - 1, offset 0x000 INCR (W): writedata[BIN_AW-1:0] = bin index to increment.
  - 1, offset 0x004 CTRL (W): bit0=1 starts a clear sweep.
  - 1, offset 0x008 STATUS (R): bit0 busy, bit1 sat_sticky, bit2 range_err_sticky.
  - 1, offset 0x00C TOTAL (R): accepted in-range increments, saturating at 0xFFFFFFFF.
  - Other CSR offsets read 0; writes to them have no effect.
- Increment:
  - Bin becomes min(bin+1, 0xFFFFFFFF).
  - An increment of a bin already at 0xFFFFFFFF sets sat_sticky.
  - If writedata[31:BIN_AW] ≠ 0, the increment is dropped, range_err_sticky is set and TOTAL is unchanged.
- Direct bin write: only when byteenable=4'hF; any other byteenable drops the write with no effect.
- Coherence:
  - Reads and increments must reflect every write/increment accepted earlier, including back-to-back increments to the same bin.
  - Forwarding from the RMW pipeline is mandatory.
- State machine: INIT → IDLE ↔ CLEAR.
  - INIT: entered on reset; sweeps all bins to 0. Identical to CLEAR.
  - CLEAR: one bin per cycle for NUM_BINS cycles. At sweep start, TOTAL and both sticky bits are zeroed.
  - IDLE: accepts commands.
- read and write asserted in the same cycle: the write is executed and the read is ignored (no readdatavalid).
- Reset mid-operation: in-flight increments and pending readdatavalid are discarded; the block re-enters INIT.

## Timing
- Reset values:
  - s0_waitrequest=1, s0_readdatavalid=0, s0_readdata=0.
  - TOTAL=0, sticky bits=0, state=INIT.
  - RAM contents undefined until the INIT sweep completes.
- s0_waitrequest is registered.
  - High in INIT/CLEAR; low in IDLE.
  - After the reset release edge: high for NUM_BINS+1 cycles, then low.
- Clear: a CTRL write accepted in cycle T gives waitrequest=1 from T+1 through T+NUM_BINS, and 0 at T+NUM_BINS+1.
  - Increments accepted at or before T complete before the sweep overwrites them.
  - STATUS.busy is not observable as 1 by the master (waitrequest hides it). It exists for debug taps.
- Read latency is fixed at 2.
  - A read accepted in cycle T gives s0_readdatavalid=1 with data in T+2.
  - One read may be accepted per cycle, fully pipelined.
  - s0_readdata holds its last value when not valid.
- INCR throughput: 1 per cycle, no waitrequest in IDLE.
  - An increment accepted in T is visible to a read or increment accepted in T+1.
- TOTAL and sticky bits update in the cycle after the increment is accepted.

## Test plan
- Reset: deassert reset_reset_n → waitrequest low after exactly 257 cycles (BIN_AW=8); then read bins 0, 5, 255 → each returns 0 with readdatavalid at T+2.
- Back-to-back increments: INCR bin 7 three consecutive cycles, then read 0x01C the next cycle → 3; TOTAL=3; STATUS=0.
- Direct write and saturation: write 0xFFFFFFFE to bin 9, then INCR 9 twice → bin 9 = 0xFFFFFFFF; STATUS bit1=1; TOTAL=2.
- Range error and byteenable: INCR writedata 0x100 → no bin changes; STATUS bit2=1; TOTAL unchanged. Bin write with byteenable 4'h3 → bin unchanged.
- Clear: with nonzero bins, write CTRL=1 → waitrequest high 256 cycles; afterwards all bins, TOTAL and STATUS = 0.
- Reset mid-operation: assert reset 1 cycle after an accepted read and during INCR stream → no readdatavalid pulse; INIT sweep reruns; all bins = 0.

Source files
------------

// File: rtl/hist_ram_avmm_slave.sv
// Avalon-MM histogram memory: 2^BIN_AW saturating 32-bit bins with a one-per-cycle
// pipelined increment, direct bin access, clear sweep, event total and sticky status.
module hist_ram_avmm_slave #(
  parameter int BIN_AW = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] s0_address,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [31:0] s0_writedata,
  input  logic [3:0]  s0_byteenable,
  output logic [31:0] s0_readdata,
  output logic        s0_waitrequest,
  output logic        s0_readdatavalid
);

  localparam int DATA_W   = 32;
  localparam int NUM_BINS = 1 << BIN_AW;
  localparam int CNT_W    = BIN_AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BINS);

  localparam logic [9:0] OFF_INCR   = 10'd0;
  localparam logic [9:0] OFF_CTRL   = 10'd1;
  localparam logic [9:0] OFF_STATUS = 10'd2;
  localparam logic [9:0] OFF_TOTAL  = 10'd3;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;
  typedef enum logic [2:0] {OP_RD_BIN, OP_RD_CSR, OP_WR_BIN, OP_INC, OP_INC_ERR} op_t;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  state_t              state, next_state;
  logic [CNT_W-1:0]    sweep_cnt;
  logic                sweep_en;
  logic [BIN_AW-1:0]   sweep_bin;

  logic                accept;
  logic                start_clear;
  logic                acc_vld;
  op_t                 acc_op;
  logic [BIN_AW-1:0]   acc_bin;
  logic [9:0]          csr_off;

  logic                vld_p0;
  op_t                 op_p0;
  logic [BIN_AW-1:0]   bin_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [9:0]          csr_off_p0;
  logic [DATA_W-1:0]   rd_data_p0;

  logic                wr_vld_p1;
  logic [BIN_AW-1:0]   wr_bin_p1;
  logic [DATA_W-1:0]   wr_data_p1;

  logic [DATA_W-1:0]   mem [NUM_BINS];

  logic [DATA_W-1:0]   total;
  logic                sat_sticky;
  logic                rerr_sticky;

  logic                fwd_hit;
  logic [DATA_W-1:0]   cur_val;
  logic [DATA_W-1:0]   new_val;
  logic [DATA_W-1:0]   csr_rdata;
  logic [DATA_W-1:0]   rd_val;
  logic                ram_we;
  logic                rd_issue;
  logic                unused_bits;

  assign unused_bits = ^{s0_address[31:13], s0_address[1:0]};

  assign accept  = (s0_read | s0_write) & ~s0_waitrequest;
  assign csr_off = s0_address[11:2];

  always_comb begin
    acc_vld     = 1'b0;
    acc_op      = OP_RD_BIN;
    acc_bin     = s0_address[BIN_AW+1:2];
    start_clear = 1'b0;
    if (accept) begin
      if (s0_write) begin
        if (!s0_address[12]) begin
          if (s0_byteenable == 4'hF) begin
            acc_vld = 1'b1;
            acc_op  = OP_WR_BIN;
          end
        end else if (csr_off == OFF_INCR) begin
          acc_vld = 1'b1;
          acc_bin = s0_writedata[BIN_AW-1:0];
          acc_op  = (s0_writedata[DATA_W-1:BIN_AW] == '0) ? OP_INC : OP_INC_ERR;
        end else if (csr_off == OFF_CTRL) begin
          start_clear = s0_writedata[0];
        end
      end else begin
        acc_vld = 1'b1;
        acc_op  = s0_address[12] ? OP_RD_CSR : OP_RD_BIN;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT, ST_CLEAR: if (sweep_cnt == CNT_LAST) next_state = ST_IDLE;
      ST_IDLE:           if (start_clear) next_state = ST_CLEAR;
      default:           next_state = ST_INIT;
    endcase
  end

  // Sweep count 0 is an idle slot after reset, so INIT lasts one cycle longer than CLEAR.
  assign sweep_en  = (state != ST_IDLE) && (sweep_cnt != '0);
  assign sweep_bin = sweep_cnt[BIN_AW-1:0] - BIN_AW'(1);

  // Stage p0: RAM data may lag by the write retiring this cycle, so forward it.
  assign fwd_hit  = wr_vld_p1 && (wr_bin_p1 == bin_p0);
  assign cur_val  = fwd_hit ? wr_data_p1 : rd_data_p0;
  assign new_val  = (op_p0 == OP_WR_BIN) ? wdata_p0 : sat_inc(cur_val);
  assign ram_we   = vld_p0 && ((op_p0 == OP_WR_BIN) || (op_p0 == OP_INC));
  assign rd_issue = vld_p0 && ((op_p0 == OP_RD_BIN) || (op_p0 == OP_RD_CSR));

  always_comb begin
    csr_rdata = '0;
    case (csr_off_p0)
      OFF_STATUS: csr_rdata = {{(DATA_W-3){1'b0}}, rerr_sticky, sat_sticky, (state != ST_IDLE)};
      OFF_TOTAL:  csr_rdata = total;
      default:    csr_rdata = '0;
    endcase
  end

  assign rd_val = (op_p0 == OP_RD_CSR) ? csr_rdata : cur_val;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state            <= ST_INIT;
      sweep_cnt        <= '0;
      s0_waitrequest   <= 1'b1;
      vld_p0           <= 1'b0;
      wr_vld_p1        <= 1'b0;
      s0_readdatavalid <= 1'b0;
      s0_readdata      <= '0;
      total            <= '0;
      sat_sticky       <= 1'b0;
      rerr_sticky      <= 1'b0;
    end else begin
      state          <= next_state;
      s0_waitrequest <= (next_state != ST_IDLE);
      if (next_state == ST_IDLE) sweep_cnt <= '0;
      else if (state == ST_IDLE) sweep_cnt <= CNT_W'(1);
      else                       sweep_cnt <= sweep_cnt + CNT_W'(1);

      vld_p0           <= acc_vld;
      wr_vld_p1        <= ram_we;
      s0_readdatavalid <= rd_issue;
      if (rd_issue) s0_readdata <= rd_val;

      // A clear start outranks stat updates from the increment retiring on the same edge.
      if (start_clear) begin
        total       <= '0;
        sat_sticky  <= 1'b0;
        rerr_sticky <= 1'b0;
      end else begin
        if (vld_p0 && (op_p0 == OP_INC)) begin
          total <= sat_inc(total);
          if (&cur_val) sat_sticky <= 1'b1;
        end
        if (vld_p0 && (op_p0 == OP_INC_ERR)) rerr_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    op_p0      <= acc_op;
    bin_p0     <= acc_bin;
    wdata_p0   <= s0_writedata;
    csr_off_p0 <= csr_off;
    wr_bin_p1  <= bin_p0;
    wr_data_p1 <= new_val;
  end

  // Stage p1: single write port; sweep and pipeline writes never coincide.
  always_ff @(posedge clk_clk) begin
    if (sweep_en)    mem[sweep_bin] <= '0;
    else if (ram_we) mem[bin_p0]    <= new_val;
    rd_data_p0 <= mem[acc_bin];
  end

endmodule

// File: tb/tb_hist_ram_avmm_slave.sv
// Scoreboard bench for hist_ram_avmm_slave: reads push expectations, a negedge monitor
// pops them on readdatavalid and also evaluates queued scalar checks.
module tb_hist_ram_avmm_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = 4'h0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        readdatavalid;

  hist_ram_avmm_slave #(.BIN_AW(8)) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .s0_address      (address),
    .s0_read         (read),
    .s0_write        (write),
    .s0_writedata    (writedata),
    .s0_byteenable   (byteenable),
    .s0_readdata     (readdata),
    .s0_waitrequest  (waitrequest),
    .s0_readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; string name; } rexp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } dchk_t;

  rexp_t rq[$];
  dchk_t dq[$];
  int n_chk = 0;
  int n_fail = 0;
  rexp_t mon_r;
  dchk_t mon_d;

  always @(negedge clk) begin
    if (readdatavalid) begin
      n_chk++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdv: got readdatavalid=1 data %h at cyc %0d, required no pulse", readdata, cyc);
      end else begin
        mon_r = rq.pop_front();
        if (readdata !== mon_r.data || cyc != mon_r.cyc) begin
          n_fail++;
          $display("FAIL %s: got %h at cyc %0d, required %h at cyc %0d",
                   mon_r.name, readdata, cyc, mon_r.data, mon_r.cyc);
        end
      end
    end
    while (dq.size() > 0) begin
      mon_d = dq.pop_front();
      n_chk++;
      if (mon_d.act !== mon_d.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)",
                 mon_d.name, mon_d.act, mon_d.act, mon_d.exp, mon_d.exp);
      end
    end
  end

  function automatic void push_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    dq.push_back('{name: nm, act: a, exp: e});
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (waitrequest && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (waitrequest) push_chk("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wait_ready();
    address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input bit chk, input string nm);
    wait_ready();
    address = a; read = 1'b1; write = 1'b0;
    if (chk) rq.push_back('{data: e, cyc: cyc + 2, name: nm});
    @(negedge clk);
  endtask

  task automatic idle();
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic release_and_time(input string nm);
    int n = 0;
    rst_n = 1'b1;
    while (waitrequest && n < 1000) begin
      @(negedge clk);
      n++;
    end
    push_chk(nm, n, 32'd257);
  endtask

  initial begin
    bit saw;
    int m;

    repeat (3) @(negedge clk);
    push_chk("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    push_chk("rst_readdatavalid", {31'd0, readdatavalid}, 32'd0);
    push_chk("rst_readdata", readdata, 32'd0);
    release_and_time("init_wait_cycles");

    rd(32'h0000, 32'h0, 1, "bin0_after_init");
    rd(32'h0014, 32'h0, 1, "bin5_after_init");
    rd(32'h03FC, 32'h0, 1, "bin255_after_init");
    rd(32'h100C, 32'h0, 1, "total_after_init");
    rd(32'h1008, 32'h0, 1, "status_after_init");
    idle();

    wr(32'h1000, 32'd7, 4'hF);
    wr(32'h1000, 32'd7, 4'hF);
    wr(32'h1000, 32'd7, 4'hF);
    rd(32'h001C, 32'd3, 1, "bin7_b2b_incr");
    rd(32'h100C, 32'd3, 1, "total_3");
    rd(32'h1008, 32'd0, 1, "status_clean");
    idle();

    wr(32'h0024, 32'hFFFF_FFFE, 4'hF);
    wr(32'h1000, 32'd9, 4'hF);
    wr(32'h1000, 32'd9, 4'hF);
    rd(32'h0024, 32'hFFFF_FFFF, 1, "bin9_saturated");
    rd(32'h1008, 32'd2, 1, "status_sat");
    rd(32'h100C, 32'd5, 1, "total_5");
    idle();

    wr(32'h1000, 32'h100, 4'hF);
    wr(32'h001C, 32'h55, 4'h3);
    rd(32'h0000, 32'd0, 1, "bin0_range_drop");
    rd(32'h1008, 32'd6, 1, "status_range");
    rd(32'h100C, 32'd5, 1, "total_unchanged");
    rd(32'h001C, 32'd3, 1, "bin7_partial_be");
    rd(32'h041C, 32'd3, 1, "bin7_alias");
    rd(32'h1010, 32'd0, 1, "csr_unmapped");
    rd(32'h1000, 32'd0, 1, "csr_incr_reads0");
    idle();

    wait_ready();
    address = 32'h0050; writedata = 32'h1234; byteenable = 4'hF; read = 1'b1; write = 1'b1;
    @(negedge clk);
    wr(32'h1000, 32'd20, 4'hF);
    rd(32'h0050, 32'h1235, 1, "bin20_rw_then_incr");
    wr(32'h0078, 32'd10, 4'hF);
    wr(32'h1000, 32'd30, 4'hF);
    rd(32'h0078, 32'd11, 1, "bin30_write_fwd");
    rd(32'h100C, 32'd7, 1, "total_7");
    idle();

    wr(32'h1000, 32'd40, 4'hF);
    wr(32'h1004, 32'd1, 4'hF);
    idle();
    m = 0;
    while (waitrequest && m < 1000) begin
      m++;
      @(negedge clk);
    end
    push_chk("clear_wait_cycles", m, 32'd256);
    rd(32'h001C, 32'd0, 1, "bin7_cleared");
    rd(32'h0024, 32'd0, 1, "bin9_cleared");
    rd(32'h0050, 32'd0, 1, "bin20_cleared");
    rd(32'h00A0, 32'd0, 1, "bin40_incr_before_clear");
    rd(32'h03FC, 32'd0, 1, "bin255_cleared");
    rd(32'h100C, 32'd0, 1, "total_cleared");
    rd(32'h1008, 32'd0, 1, "status_cleared");
    idle();

    wr(32'h1000, 32'd50, 4'hF);
    wr(32'h1000, 32'd50, 4'hF);
    rd(32'h00C8, 32'd0, 0, "");
    address = 32'h1000; writedata = 32'd50; byteenable = 4'hF; write = 1'b1; read = 1'b0;
    rst_n = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw = saw | readdatavalid;
    end
    push_chk("midrst_no_rdv", {31'd0, saw}, 32'd0);
    idle();
    release_and_time("reinit_wait_cycles");
    rd(32'h00C8, 32'd0, 1, "bin50_after_reinit");
    rd(32'h100C, 32'd0, 1, "total_after_reinit");
    idle();

    repeat (4) @(negedge clk);
    push_chk("pending_reads", rq.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
